fml_arbiter: RTL and testbench

Two-master arbiter sharing the single FML SDRAM port between the framebuffer read engine (master 0) and the host/register-side port (master 1). It takes a full 4-beat FML burst from one master at a time. Master 0 has fixed priority, and an optional starvation guard bounds host latency. It sits between the framebuffer/host FML masters and the SDRAM controller, in the clk_sys_i domain.

---
 rtl/fml_pkg.sv | 34 +++
 rtl/fml_arbiter.sv | 175 +++++++++++++++++
 tb/tb_fml_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fml_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fml_pkg
// Description : Shared constants for the two-master FML arbiter: burst
//               length, state encoding and one-hot grant values.
// Revision    : 1.0 - initial release
// ============================================================================
package fml_pkg;

    // A full FML burst: the acknowledge beat plus three following beats
    localparam int c_FML_BURST_LEN = 4;

    // Last value of the post-ack beat counter before returning to idle
    localparam logic [1:0] c_BURST_LAST = 2'(c_FML_BURST_LEN - 2);

    // State encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_BURST = ST_BURST
    } fml_state_e;

    // One-hot grant values
    localparam logic [1:0] c_GNT_NONE = 2'b00;
    localparam logic [1:0] c_GNT_M0   = 2'b01;
    localparam logic [1:0] c_GNT_M1   = 2'b10;

endpackage : fml_pkg
`default_nettype wire

// File: rtl/fml_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fml_arbiter
// Description : Shares one FML SDRAM port between the framebuffer read engine
//               (master 0, fixed priority) and the host port (master 1), one
//               full 4-beat burst at a time.
//               Optional macro FML_ARB_STARVE_GUARD_EN adds a starvation
//               guard that forces a master-1 grant after g_max_wait
//               consecutive master-0 grants taken while master 1 waited.
// Revision    : 1.0 - initial release
// ============================================================================
module fml_arbiter
    import fml_pkg::*;
#(
    parameter int g_fml_depth = 26,
    parameter int g_max_wait  = 4
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_n_i,

    input  logic [g_fml_depth-1:0] m0_adr_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [3:0]             m0_sel_i,
    input  logic [31:0]            m0_dw_i,
    output logic [31:0]            m0_dr_o,
    output logic                   m0_ack_o,

    input  logic [g_fml_depth-1:0] m1_adr_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [3:0]             m1_sel_i,
    input  logic [31:0]            m1_dw_i,
    output logic [31:0]            m1_dr_o,
    output logic                   m1_ack_o,

    output logic [g_fml_depth-1:0] fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    output logic [3:0]             fml_sel,
    output logic [31:0]            fml_do,
    input  logic [31:0]            fml_di,
    input  logic                   fml_ack,

    output logic [1:0]             grant_o
);

    fml_state_e r_state;
    fml_state_e w_state_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_pick;
    logic       w_force_m1;
    logic       w_any_req;
    logic       w_sel_m1;

    // Grant decision: master 0 wins unless only master 1 asks or the guard
    // insists on master 1
    function automatic logic [1:0] pick_winner(input logic m0_req,
                                               input logic m1_req,
                                               input logic force_m1);
        if (m1_req && (!m0_req || force_m1)) begin
            return c_GNT_M1;
        end else if (m0_req) begin
            return c_GNT_M0;
        end else begin
            return c_GNT_NONE;
        end
    endfunction

    assign w_any_req = m0_stb_i | m1_stb_i;
    assign w_pick    = pick_winner(m0_stb_i, m1_stb_i, w_force_m1);

`ifdef FML_ARB_STARVE_GUARD_EN
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_nxt;

    assign w_force_m1 = (r_wait_cnt == 4'(g_max_wait));

    // Count master-0 grants handed out while master 1 was left waiting
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if ((r_state == S_IDLE) && w_any_req) begin
            if (!m1_stb_i || (w_pick == c_GNT_M1)) begin
                w_wait_cnt_nxt = 4'd0;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end
`else
    // Strict priority: never force master 1 (a legal g_max_wait is never 0)
    assign w_force_m1 = (g_max_wait == 0);
`endif

    // Next-state, grant and beat-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 2'd0;
                if (w_any_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (fml_ack) begin
                    w_state_nxt = S_BURST;
                    w_cnt_nxt   = 2'd0;
                end
            end
            S_BURST: begin
                if (r_cnt == c_BURST_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = c_GNT_NONE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = c_GNT_NONE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // State, grant and beat-counter registers
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_grant <= c_GNT_NONE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Master-0 path is the default mux leg, so idle outputs follow master 0
    assign w_sel_m1 = (r_grant == c_GNT_M1);

    assign fml_adr  = w_sel_m1 ? m1_adr_i : m0_adr_i;
    assign fml_we   = w_sel_m1 ? m1_we_i  : m0_we_i;
    assign fml_sel  = w_sel_m1 ? m1_sel_i : m0_sel_i;
    assign fml_do   = w_sel_m1 ? m1_dw_i  : m0_dw_i;
    assign fml_stb  = (r_state == S_REQ);
    assign grant_o  = r_grant;

    // Acknowledge passes straight through to the owner only
    assign m0_ack_o = fml_stb & fml_ack & (r_grant == c_GNT_M0);
    assign m1_ack_o = fml_stb & fml_ack & (r_grant == c_GNT_M1);

    assign m0_dr_o  = fml_di;
    assign m1_dr_o  = fml_di;

endmodule : fml_arbiter
`default_nettype wire

// File: tb/tb_fml_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fml_arbiter
// Description : Self-checking bench for fml_arbiter: directed master requests,
//               a small SDRAM-controller model and a scoreboard monitor that
//               checks every acknowledged burst beat by beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fml_arbiter;

    typedef struct {
        logic [1:0]  gnt;
        logic [25:0] adr;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fml_di;
    logic        fml_ack;

    logic [25:0] m0_adr_w, m1_adr_w;
    logic        m0_stb_w, m1_stb_w, m0_we_w, m1_we_w;
    logic [3:0]  m0_sel_w, m1_sel_w;
    logic [31:0] m0_dw_w, m1_dw_w;
    logic        m0_busy, m1_busy;

    wire  [31:0] m0_dr, m1_dr;
    wire         m0_ack, m1_ack;
    wire  [25:0] fml_adr;
    wire         fml_stb, fml_we;
    wire  [3:0]  fml_sel;
    wire  [31:0] fml_do;
    wire  [1:0]  grant;

    exp_t        sb[$];
    int          ack_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          ctl_bursts = 0;
    int          mon_bursts = 0;
    int          mon_beat = 0;
    logic        mon_owner = 1'b0;
    logic [25:0] mon_adr = '0;
    logic [31:0] mon_base = '0;

    logic [25:0] cmd_adr[2];
    logic        cmd_we[2];
    int          cmd_reps[2];
    int          cmd_seq[2];

    always #5 clk = ~clk;

    fml_arbiter #(.g_fml_depth(26), .g_max_wait(4)) dut (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .m0_adr_i  (m0_adr_w),
        .m0_stb_i  (m0_stb_w),
        .m0_we_i   (m0_we_w),
        .m0_sel_i  (m0_sel_w),
        .m0_dw_i   (m0_dw_w),
        .m0_dr_o   (m0_dr),
        .m0_ack_o  (m0_ack),
        .m1_adr_i  (m1_adr_w),
        .m1_stb_i  (m1_stb_w),
        .m1_we_i   (m1_we_w),
        .m1_sel_i  (m1_sel_w),
        .m1_dw_i   (m1_dw_w),
        .m1_dr_o   (m1_dr),
        .m1_ack_o  (m1_ack),
        .fml_adr   (fml_adr),
        .fml_stb   (fml_stb),
        .fml_we    (fml_we),
        .fml_sel   (fml_sel),
        .fml_do    (fml_do),
        .fml_di    (fml_di),
        .fml_ack   (fml_ack),
        .grant_o   (grant)
    );

    // Per-beat byte enables and write data each master drives
    function automatic logic [3:0] selof(input int n, input int k);
        logic [3:0] one;
        one = 4'b0001 << k;
        return (n == 0) ? ~one : one;
    endfunction

    function automatic logic [31:0] wdat(input int n, input int k, input logic [25:0] a);
        return {a[15:0], 8'(n), 8'(k)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Master models: take a command, hold stb until ack, then walk the beats
    for (genvar g = 0; g < 2; g++) begin : g_mst
        logic [25:0] adr;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dw;
        logic        ack_in;
        logic        busy;
        int          beat;
        int          reps;
        int          last_seq;

        assign ack_in = (g == 0) ? m0_ack : m1_ack;
        assign busy   = stb || (beat != 0) || (cmd_seq[g] != last_seq);

        if (g == 0) begin : g_p0
            assign m0_adr_w = adr;
            assign m0_stb_w = stb;
            assign m0_we_w  = we;
            assign m0_sel_w = sel;
            assign m0_dw_w  = dw;
            assign m0_busy  = busy;
        end else begin : g_p1
            assign m1_adr_w = adr;
            assign m1_stb_w = stb;
            assign m1_we_w  = we;
            assign m1_sel_w = sel;
            assign m1_dw_w  = dw;
            assign m1_busy  = busy;
        end

        initial begin
            logic seen;
            adr = '0; stb = 1'b0; we = 1'b0; sel = '0; dw = '0;
            beat = 0; reps = 0; last_seq = 0;
            forever begin
                @(negedge clk);
                seen = ack_in;
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    stb  = 1'b0;
                    beat = 0;
                end else if (seen) begin
                    stb  = 1'b0;
                    beat = 1;
                    sel  = selof(g, 1);
                    dw   = wdat(g, 1, adr);
                end else if (beat == 1 || beat == 2) begin
                    beat++;
                    sel = selof(g, beat);
                    dw  = wdat(g, beat, adr);
                end else if (beat == 3) begin
                    beat = 0;
                    if (reps > 0) begin
                        reps--;
                        stb = 1'b1;
                        sel = selof(g, 0);
                        dw  = wdat(g, 0, adr);
                    end
                end else if (cmd_seq[g] != last_seq) begin
                    last_seq = cmd_seq[g];
                    adr  = cmd_adr[g];
                    we   = cmd_we[g];
                    reps = cmd_reps[g];
                    stb  = 1'b1;
                    sel  = selof(g, 0);
                    dw   = wdat(g, 0, adr);
                end
            end
        end
    end

    // SDRAM controller model: ack after ack_delay cycles, then 3 more beats
    initial begin
        int beats_left;
        int dly;
        logic [31:0] base;
        beats_left = 0; dly = 0; base = '0;
        fml_ack = 1'b0;
        fml_di  = '0;
        forever begin
            @(posedge clk);
            #1;
            fml_ack = 1'b0;
            if (!rst_n) begin
                beats_left = 0;
                dly        = 0;
            end else if (beats_left > 0) begin
                fml_di = base + 32'(4 - beats_left);
                beats_left--;
            end else if (fml_stb) begin
                if (dly >= ack_delay) begin
                    base       = 32'hD000_0000 + 32'(ctl_bursts * 16);
                    fml_ack    = 1'b1;
                    fml_di     = base;
                    beats_left = 3;
                    dly        = 0;
                    ctl_bursts++;
                end else begin
                    dly++;
                end
            end
        end
    end

    task automatic check_beat(input int k);
        logic [31:0] dr;
        dr = mon_owner ? m1_dr : m0_dr;
        chk("beat_rdata", 64'(dr), 64'(mon_base + 32'(k)));
        chk("beat_wdata", 64'(fml_do), 64'(wdat(int'(mon_owner), k, mon_adr)));
        chk("beat_sel", 64'(fml_sel), 64'(selof(int'(mon_owner), k)));
        chk("beat_grant", 64'(grant), 64'(mon_owner ? 2'b10 : 2'b01));
        if (k > 0) chk("beat_stb_low", 64'(fml_stb), 64'(0));
    endtask

    // Scoreboard monitor: every acknowledged burst pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mon_beat = 0;
            end else if (mon_beat > 0) begin
                check_beat(mon_beat);
                mon_beat = (mon_beat == 3) ? 0 : mon_beat + 1;
            end else if (fml_stb && fml_ack) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_burst actual grant=%0h adr=%0h required=no burst", grant, fml_adr);
                end else begin
                    e = sb.pop_front();
                    chk("ack_grant", 64'(grant), 64'(e.gnt));
                    chk("ack_adr", 64'(fml_adr), 64'(e.adr));
                    chk("ack_we", 64'(fml_we), 64'(e.we));
                    chk("ack_route", 64'({m1_ack, m0_ack}), 64'(e.gnt));
                    mon_owner = e.gnt[1];
                    chk("owner_stb_held", 64'(mon_owner ? m1_stb_w : m0_stb_w), 64'(1));
                    mon_adr  = e.adr;
                    mon_base = 32'hD000_0000 + 32'(mon_bursts * 16);
                    mon_bursts++;
                    ack_cyc.push_back(cyc);
                    check_beat(0);
                    mon_beat = 1;
                end
            end
        end
    end

    task automatic issue(input int n, input logic [25:0] a, input logic w, input int r);
        cmd_adr[n]  = a;
        cmd_we[n]   = w;
        cmd_reps[n] = r;
        cmd_seq[n]  = cmd_seq[n] + 1;
    endtask

    task automatic expect_burst(input int n, input logic [25:0] a, input logic w);
        exp_t e;
        e.gnt = (n == 0) ? 2'b01 : 2'b10;
        e.adr = a;
        e.we  = w;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = !m0_busy && !m1_busy && (sb.size() == 0) && (grant == 2'b00) && (mon_beat == 0);
        end
        chk(name, 64'(done), 64'(1));
        sb.delete();
    endtask

    task automatic wait_cond_m1stb(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = m1_stb_w;
        end
    endtask

    initial begin
        logic ok;
        int   n;
        cmd_seq[0] = 0; cmd_seq[1] = 0;
        cmd_adr[0] = '0; cmd_adr[1] = '0;
        cmd_we[0] = 1'b0; cmd_we[1] = 1'b0;
        cmd_reps[0] = 0; cmd_reps[1] = 0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stb", 64'(fml_stb), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_acks", 64'({m1_ack, m0_ack}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lone m1 read of 0x100, repeated once to measure burst spacing
        ack_cyc.delete();
        expect_burst(1, 26'h100, 1'b0);
        expect_burst(1, 26'h100, 1'b0);
        issue(1, 26'h100, 1'b0, 1);
        wait_cond_m1stb(ok);
        chk("m1_stb_raise", 64'(ok), 64'(1));
        chk("lat_still_idle", 64'(fml_stb), 64'(0));
        @(negedge clk);
        chk("lat_stb", 64'(fml_stb), 64'(1));
        chk("lat_adr", 64'(fml_adr), 64'(26'h100));
        wait_done("lone_done", 100);
        chk("ack_count", 64'(ack_cyc.size()), 64'(2));
        if (ack_cyc.size() == 2) chk("burst_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'(5));

        // Reset in the middle of a burst
        expect_burst(1, 26'h200, 1'b0);
        issue(1, 26'h200, 1'b0, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = m1_ack;
        end
        chk("rst_burst_ack", 64'(ok), 64'(1));
        @(posedge clk);
        #3;
        chk("pre_rst_grant", 64'(grant), 64'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("async_rst_stb", 64'(fml_stb), 64'(0));
        chk("async_rst_grant", 64'(grant), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        expect_burst(1, 26'h300, 1'b0);
        issue(1, 26'h300, 1'b0, 0);
        wait_done("post_rst_done", 100);

        // Simultaneous m0 read and m1 write: m0 first, then m1's write beats
        expect_burst(0, 26'h400, 1'b0);
        expect_burst(1, 26'h500, 1'b1);
        issue(0, 26'h400, 1'b0, 0);
        issue(1, 26'h500, 1'b1, 0);
        wait_done("simul_done", 100);

        // Controller holds ack off for 7 cycles
        ack_delay = 7;
        expect_burst(0, 26'h600, 1'b0);
        issue(0, 26'h600, 1'b0, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = fml_stb;
        end
        chk("delay_stb_rise", 64'(ok), 64'(1));
        n = 0;
        for (int i = 0; i < 30 && !fml_ack; i++) begin
            chk("delay_stb", 64'(fml_stb), 64'(1));
            chk("delay_adr", 64'(fml_adr), 64'(26'h600));
            chk("delay_grant", 64'(grant), 64'(2'b01));
            n++;
            @(negedge clk);
        end
        chk("delay_wait_cycles", 64'(n), 64'(7));
        wait_done("delay_done", 100);
        ack_delay = 0;

        // m0 requests continuously while m1 waits
`ifdef FML_ARB_STARVE_GUARD_EN
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) expect_burst(0, 26'h700, 1'b0);
            expect_burst(1, 26'h800, 1'b0);
        end
        issue(0, 26'h700, 1'b0, 7);
        issue(1, 26'h800, 1'b0, 1);
`else
        for (int i = 0; i < 20; i++) expect_burst(0, 26'h700, 1'b0);
        expect_burst(1, 26'h800, 1'b0);
        issue(0, 26'h700, 1'b0, 19);
        issue(1, 26'h800, 1'b0, 0);
`endif
        wait_done("starve_done", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fml_arbiter
`default_nettype wire
